// File: rtl/fir_ctrl_pkg.sv
// Shared types, default coefficient set and saturation helper for the
// time-multiplexed FIR MAC sequencer.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int CW_DEFAULT = 16;

    // 16-tap low-pass, unity-ish DC gain (sum 32766)
    localparam logic signed [CW_DEFAULT-1:0] DEFAULT_COEFS [16] = '{
        16'sd311,  16'sd469,  16'sd917,  16'sd1582,
        16'sd2352, 16'sd3091, 16'sd3671, 16'sd3990,
        16'sd3990, 16'sd3671, 16'sd3091, 16'sd2352,
        16'sd1582, 16'sd917,  16'sd469,  16'sd311
    };

    function automatic logic signed [CW_DEFAULT-1:0] default_coef(input int i);
        logic [3:0] idx;
        idx = i[3:0];
        if (i >= 0 && i < 16) return DEFAULT_COEFS[idx];
        return '0;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: host writes the shadow bank, and the
// whole bank is copied to the active side only on a sample-accept edge.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = CW_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coef_wr,
    input  logic [$clog2(N)-1:0]         coef_addr,
    input  logic signed [CW-1:0]         coef_data,
    input  logic                         coef_commit,
    input  logic                         accept,
    input  logic [$clog2(N)-1:0]         tap_idx,
    output logic signed [CW-1:0]         coef,
    output logic                         coef_pending
);

    logic signed [CW-1:0] shadow_q [N];
    logic signed [CW-1:0] active_q [N];
    logic                 swap;

    // A commit arriving with the accept still applies to that sample.
    assign swap = accept && (coef_pending || coef_commit);
    assign coef = active_q[tap_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_pending <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= CW'(default_coef(i));
                active_q[i] <= CW'(default_coef(i));
            end
        end else begin
            // NOTE: non-blocking copy reads the pre-write shadow, so a same-edge write stays shadow-only.
            if (swap) begin
                for (int i = 0; i < N; i++) active_q[i] <= shadow_q[i];
            end
            if (coef_wr) shadow_q[coef_addr] <= coef_data;
            if (swap)             coef_pending <= 1'b0;
            else if (coef_commit) coef_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiplier and accumulator walk N taps per
// accepted sample, then emit a saturated result.
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 14,
    parameter int CW    = CW_DEFAULT,
    parameter int OUTW  = WIDTH + 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic signed [OUTW-1:0]   dout,
    output logic                     dout_valid,
    input  logic                     coef_wr,
    input  logic [$clog2(N)-1:0]     coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    input  logic                     coef_commit,
    output logic                     coef_pending,
    output logic                     busy
);

    localparam int TW = $clog2(N);
    localparam int PW = WIDTH + CW;
    localparam int AW = WIDTH + CW + TW;

    state_t                  state_q, state_d;
    logic                    accept;
    logic [TW-1:0]           wptr_q, base_q, tap_q, rd_idx;
    logic signed [WIDTH-1:0] hist_q [N];
    logic signed [WIDTH-1:0] x_tap;
    logic signed [CW-1:0]    coef;
    logic signed [PW-1:0]    prod_q;
    logic signed [AW-1:0]    acc_q;

    fir_coeff_bank #(.N(N), .CW(CW)) u_bank (
        .clk          (clk),
        .rst          (rst),
        .coef_wr      (coef_wr),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .coef_commit  (coef_commit),
        .accept       (accept),
        .tap_idx      (tap_q),
        .coef         (coef),
        .coef_pending (coef_pending)
    );

    assign din_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_idx    = base_q - tap_q;
    assign x_tap     = hist_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:    if (din_valid) begin
                         accept  = 1'b1;
                         state_d = MAC;
                     end
            MAC:     if (tap_q == TW'(N - 1)) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Product of tap k is registered on one edge and accumulated on the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            base_q     <= '0;
            tap_q      <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            // NOTE: history lives in flops rather than RAM precisely so reset can zero it.
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
        end else begin
            dout_valid <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    hist_q[wptr_q] <= din;
                    base_q         <= wptr_q;
                    wptr_q         <= wptr_q + TW'(1);
                    tap_q          <= '0;
                    prod_q         <= '0;
                    acc_q          <= '0;
                end
                MAC: begin
                    prod_q <= PW'(coef) * PW'(x_tap);
                    acc_q  <= acc_q + AW'(prod_q);
                    tap_q  <= tap_q + TW'(1);
                end
                DRAIN: acc_q <= acc_q + AW'(prod_q);
                OUT: begin
                    dout       <= OUTW'(sat(64'(acc_q), OUTW));
                    dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. It sequences one shared multiplier and accumulator across N taps per accepted ADC sample, replacing the fully parallel N-multiplier FIR in resource-limited channels. It owns the sample history, a double-buffered coefficient bank that the host updates at runtime, and a valid/ready sample handshake. It sits between the ADC capture stage and the downstream demodulation and decimation logic.

Parameters:
N, 16, number of taps (power of 2, ≥2)
WIDTH, 14, signed ADC sample width
CW, 16, signed coefficient width
OUTW, WIDTH+16, signed output width; the output saturates to this width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
din  in  WIDTH  signed sample
din_valid  in  1  sample offered
din_ready  out  1  high only in IDLE
dout  out  OUTW  signed filtered result
dout_valid  out  1  one-cycle pulse when dout updates
coef_wr  in  1  write coef_data into shadow bank
coef_addr  in  $clog2(N)  tap index
coef_data  in  CW  signed coefficient
coef_commit  in  1  request a shadow→active swap
coef_pending  out  1  commit requested, swap not yet applied
busy  out  1  state != IDLE

Behaviour:
- Reset values: dout=0, dout_valid=0, din_ready=1 once rst deasserts, coef_pending=0, busy=0.
- Reset clears the history buffer to 0 and loads both coefficient banks with the package defaults.
- Reset asserted mid-computation aborts the computation: no dout_valid, accumulator discarded.
- Function: dout = sat_OUTW( Σ_{i=0..N-1} coef_active[i] * x[n-i] ), where x[n] is the latest accepted sample and the history starts at 0.
- History is an N-entry circular buffer. On accept, x[n] is written at wptr and wptr then increments modulo N. Tap i reads entry (wptr_at_accept - i) mod N.
- FSM states:
  - IDLE: din_ready=1. On din_valid: accept, clear the accumulator, go to MAC.
  - MAC: N cycles, tap index 0..N-1. Each cycle registers one product (WIDTH+CW bits). After tap N-1, go to DRAIN.
  - DRAIN: 1 cycle. Adds the final product.
  - OUT: 1 cycle. Registers the saturated dout, pulses dout_valid, returns to IDLE.
- Latency: accept at edge E0, dout_valid high in the cycle after edge E0+N+2. The earliest next accept is E0+N+3, so with din_valid held high, throughput is 1 sample per N+3 cycles.
- Arithmetic:
  - Accumulator width is WIDTH+CW+$clog2(N). No intermediate overflow is possible.
  - Final saturation clamps to [-2^(OUTW-1), 2^(OUTW-1)-1].
- Coefficient bank:
  - coef_wr writes the shadow bank only, and is legal in any state.
  - coef_addr ≥ N never occurs for power-of-2 N.
  - coef_commit sets coef_pending.
  - The swap (active←shadow, all taps) happens only on an accept edge while coef_pending=1; coef_pending clears on that same edge.
  - A computation therefore never mixes banks.
  - Commit in the same cycle as an accept: the swap applies to that sample.
  - coef_wr in the same cycle as the swap edge: the write lands in the shadow bank after the copy; it is not in the active bank.
  - Repeated commits while pending have no further effect.
- din_valid while not ready: the sample is held off, not dropped; the producer keeps it stable until accepted.

Decomposition:
- Package fir_ctrl_pkg:
  - state enum {IDLE, MAC, DRAIN, OUT}
  - CW_DEFAULT=16
  - default 16-tap low-pass coefficients {311,469,917,1582,2352,3091,3671,3990,3990,3671,3091,2352,1582,917,469,311} (sum 32766)
  - sat() function
- Sub-module fir_coeff_bank: shadow and active arrays, write port, commit/pending logic, tap read mux.

Test Plan:
- Impulse: din=1 then 0×16, default coefficients → successive dout = 311,469,917,…,469,311, then 0.
- DC: din=1000 held for ≥16 accepts → dout settles at 32,766,000. With din=-8192 → -268,419,072, not saturated.
- Saturation: write all taps 32767, commit, then din=-8192 for 16 samples → dout=-536,870,912 (-2^29). With din=8191 → 536,870,911.
- Handshake: din_valid held high → accepts exactly every 19 cycles (N=16). dout_valid is a 1-cycle pulse 18 cycles after each accept edge. din_ready stays low while busy.
- Coefficient swap:
  - Write tap0=1000 and commit mid-MAC → the current result uses the old coefficients; coef_pending=1 until the next accept, and the next impulse output is 1000.
  - Commit coincident with accept → the new coefficients apply to that sample.
- Reset mid-MAC: assert rst at tap 5 → no dout_valid, dout=0, history cleared. The next impulse reproduces the default impulse response exactly.
